// File: rtl/softmax_pkg.sv
// Shared types, default widths and the saturating subtract used by the softmax vector sequencer.
package softmax_pkg;

    localparam int unsigned DATA_W = 34;
    localparam int unsigned FRAC_W = 16;
    localparam int unsigned EXP_W  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EXP  = 2'd2,
        OUT  = 2'd3
    } state_t;

    // a - b clamped to the signed range of a w-bit value (w <= 63); caller truncates to w bits
    function automatic logic signed [63:0] sat_sub(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int unsigned w);
        logic signed [63:0] d;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        d  = a - b;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (d > hi) return hi;
        if (d < lo) return lo;
        return d;
    endfunction

endpackage

// File: rtl/softmax_vbuf.sv
// Vector buffer: one synchronous write port, one asynchronous read port.
module softmax_vbuf #(
    parameter  int unsigned DEPTH = 16,
    parameter  int unsigned WIDTH = 34,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // contents are don't-care after reset, so no reset on the array
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/softmax_vec_ctrl.sv
// Softmax vector sequencer: load + max search, pipelined exp issue/collect with sum, then stream exp_i with the sum.
module softmax_vec_ctrl
    import softmax_pkg::*;
#(
    parameter  int unsigned DATA_W  = softmax_pkg::DATA_W,
    parameter  int unsigned FRAC_W  = softmax_pkg::FRAC_W,
    parameter  int unsigned MAX_LEN = 16,
    parameter  int unsigned EXP_W   = softmax_pkg::EXP_W,
    localparam int unsigned SUM_W   = EXP_W + $clog2(MAX_LEN),
    localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              exp_req_valid,
    input  logic              exp_req_ready,
    output logic [DATA_W-1:0] exp_req_data,
    input  logic              exp_rsp_valid,
    input  logic [EXP_W-1:0]  exp_rsp_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [EXP_W-1:0]  out_exp,
    output logic [SUM_W-1:0]  out_sum,
    output logic              out_last,
    output logic              len_err,
    output logic              busy
);

    localparam int unsigned AW    = $clog2(MAX_LEN);
    localparam int unsigned BUF_W = (DATA_W > EXP_W) ? DATA_W : EXP_W;

    if (FRAC_W >= DATA_W) begin : g_bad_frac
        $error("FRAC_W must be smaller than DATA_W");
    end

    state_t state_q, state_d;

    logic [LEN_W-1:0]         len_q, cnt_q, iss_q, rsp_q, optr_q;
    logic signed [DATA_W-1:0] max_q;
    logic [SUM_W-1:0]         sum_q;
    logic                     len_err_q;

    logic                     in_beat, req_hs, rsp_beat, out_hs;
    logic [LEN_W-1:0]         cfg_eff, load_len, load_cnt;
    logic                     vec_end, mismatch;
    logic signed [DATA_W-1:0] smp;
    logic                     buf_we;
    logic [AW-1:0]            buf_waddr, buf_raddr;
    logic [BUF_W-1:0]         buf_wdata, buf_rdata;

    assign smp      = signed'(in_data);
    assign in_ready = (state_q == IDLE) || (state_q == LOAD);
    assign busy     = (state_q != IDLE);
    assign len_err  = len_err_q;

    assign in_beat  = in_valid && in_ready;
    assign req_hs   = exp_req_valid && exp_req_ready;
    assign rsp_beat = (state_q == EXP) && exp_rsp_valid;
    assign out_hs   = out_valid && out_ready;

    // Length bookkeeping for the beat being accepted; the first beat counts as sample 1
    assign cfg_eff  = (cfg_len == '0 || cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;
    assign load_len = (state_q == IDLE) ? cfg_eff : len_q;
    assign load_cnt = (state_q == IDLE) ? LEN_W'(1) : cnt_q + LEN_W'(1);
    assign vec_end  = in_beat && (in_last || load_cnt == load_len);
    assign mismatch = vec_end && (load_cnt != load_len);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_beat) state_d = vec_end ? EXP : LOAD;
            LOAD: if (vec_end) state_d = EXP;
            EXP:  if (rsp_beat && (rsp_q + LEN_W'(1) == len_q)) state_d = OUT;
            OUT:  if (out_hs && out_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q     <= '0;
            cnt_q     <= '0;
            iss_q     <= '0;
            rsp_q     <= '0;
            optr_q    <= '0;
            max_q     <= '0;
            sum_q     <= '0;
            len_err_q <= 1'b0;
        end else begin
            len_err_q <= mismatch;
            if (in_beat) begin
                len_q <= mismatch ? load_cnt : load_len;
                cnt_q <= load_cnt;
                if (state_q == IDLE || smp > max_q) max_q <= smp;
            end
            if (state_q == IDLE) begin
                iss_q  <= '0;
                rsp_q  <= '0;
                optr_q <= '0;
                sum_q  <= '0;
            end
            if (req_hs) iss_q <= iss_q + LEN_W'(1);
            if (rsp_beat) begin
                rsp_q <= rsp_q + LEN_W'(1);
                sum_q <= sum_q + SUM_W'(exp_rsp_data);
            end
            if (out_hs) optr_q <= optr_q + LEN_W'(1);
        end
    end

    // Samples land at cnt during loading; exp results overwrite them at rsp while iss reads ahead
    assign buf_we    = in_beat || rsp_beat;
    assign buf_waddr = (state_q == EXP)  ? AW'(rsp_q) :
                       (state_q == IDLE) ? '0 : AW'(cnt_q);
    assign buf_wdata = (state_q == EXP) ? BUF_W'(exp_rsp_data) : BUF_W'(in_data);
    assign buf_raddr = (state_q == OUT) ? AW'(optr_q) : AW'(iss_q);

    softmax_vbuf #(
        .DEPTH (MAX_LEN),
        .WIDTH (BUF_W)
    ) u_vbuf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (buf_waddr),
        .wdata (buf_wdata),
        .raddr (buf_raddr),
        .rdata (buf_rdata)
    );

    assign exp_req_valid = (state_q == EXP) && (iss_q < len_q);
    assign exp_req_data  = exp_req_valid
                         ? DATA_W'(sat_sub(64'(signed'(buf_rdata[DATA_W-1:0])), 64'(max_q), DATA_W))
                         : '0;

    assign out_valid = (state_q == OUT);
    assign out_exp   = out_valid ? buf_rdata[EXP_W-1:0] : '0;
    assign out_sum   = out_valid ? sum_q : '0;
    assign out_last  = out_valid && (optr_q == len_q - LEN_W'(1));

endmodule

// File: tb/tb_softmax_vec_ctrl.sv
// Self-checking bench for softmax_vec_ctrl: directed table, randomized vectors, reset during EXP.
module tb_softmax_vec_ctrl;

    localparam int unsigned DATA_W = 34;
    localparam int unsigned EXP_W  = 32;
    localparam int unsigned LEN_W  = 5;
    localparam int unsigned SUM_W  = 36;
    localparam int          NMAX   = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [LEN_W-1:0]  cfg_len;
    logic              in_valid, in_ready, in_last;
    logic [DATA_W-1:0] in_data;
    logic              exp_req_valid, exp_req_ready;
    logic [DATA_W-1:0] exp_req_data;
    logic              exp_rsp_valid;
    logic [EXP_W-1:0]  exp_rsp_data;
    logic              out_valid, out_ready, out_last;
    logic [EXP_W-1:0]  out_exp;
    logic [SUM_W-1:0]  out_sum;
    logic              len_err, busy;

    int checks = 0;
    int errors = 0;

    softmax_vec_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_len       (cfg_len),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_last       (in_last),
        .exp_req_valid (exp_req_valid),
        .exp_req_ready (exp_req_ready),
        .exp_req_data  (exp_req_data),
        .exp_rsp_valid (exp_rsp_valid),
        .exp_rsp_data  (exp_rsp_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_exp       (out_exp),
        .out_sum       (out_sum),
        .out_last      (out_last),
        .len_err       (len_err),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef logic [DATA_W-1:0] smp_arr_t [NMAX];
    typedef logic [EXP_W-1:0]  rsp_arr_t [NMAX];

    typedef struct {
        string             name;
        int                cfg;
        smp_arr_t          smp;
        int                last_idx;
        int                lat;
        logic [3:0]        opat;
        rsp_arr_t          rv;
        longint            exp_sum;
        int                exp_n;
        int                exp_err;
        logic [DATA_W-1:0] exp_req0;
        logic [DATA_W-1:0] exp_req1;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        in_valid      = 1'b0;
        in_last       = 1'b0;
        in_data       = '0;
        exp_req_ready = 1'b0;
        exp_rsp_valid = 1'b0;
        exp_rsp_data  = '0;
        out_ready     = 1'b0;
    endtask

    // Runs one vector against a softmax-level model. Entered just after a rising edge.
    task automatic run_vector(input int cfg, input smp_arr_t smp, input int last_idx, input int lat,
                              input int pct, input bit rand_out, input logic [3:0] opat,
                              input rsp_arr_t rv, input int abort_inflight,
                              output longint obs_sum, output int obs_n, output int obs_err,
                              output logic [DATA_W-1:0] req0, output logic [DATA_W-1:0] req1);
        int eff, end_cnt, in_idx, req_idx, rsp_idx, out_idx, cyc;
        longint mx, sum, d;
        logic [DATA_W-1:0] exp_req [NMAX];
        int due_q[$];
        bit aborted;

        eff     = (cfg == 0 || cfg > NMAX) ? NMAX : cfg;
        end_cnt = (last_idx >= 0 && last_idx + 1 < eff) ? last_idx + 1 : eff;
        mx      = longint'($signed(smp[0]));
        sum     = 0;
        for (int i = 0; i < end_cnt; i++) begin
            if (longint'($signed(smp[i])) > mx) mx = longint'($signed(smp[i]));
            sum += longint'(rv[i]);
        end
        for (int i = 0; i < end_cnt; i++) begin
            d = longint'($signed(smp[i])) - mx;
            if (d < -(longint'(1) <<< (DATA_W - 1))) d = -(longint'(1) <<< (DATA_W - 1));
            exp_req[i] = DATA_W'(d);
        end

        in_idx = 0; req_idx = 0; rsp_idx = 0; out_idx = 0; cyc = 0;
        obs_sum = 0; obs_err = 0; req0 = '0; req1 = '0; aborted = 1'b0;

        while (out_idx < end_cnt && cyc < 3000) begin
            cfg_len       = LEN_W'(cfg);
            in_valid      = (in_idx < end_cnt) && (pct >= 100 || $urandom_range(99) < pct);
            in_data       = smp[in_idx < NMAX ? in_idx : 0];
            in_last       = (in_idx == last_idx);
            exp_req_ready = (pct >= 100) || ($urandom_range(99) < pct);
            exp_rsp_valid = (due_q.size() > 0) && (due_q[0] <= cyc);
            exp_rsp_data  = exp_rsp_valid ? rv[rsp_idx] : '0;
            if (exp_rsp_valid) void'(due_q.pop_front());
            out_ready     = rand_out ? 1'($urandom_range(1)) : opat[cyc % 4];

            @(negedge clk);
            if (abort_inflight > 0 && req_idx - rsp_idx >= abort_inflight) begin
                aborted = 1'b1;
                break;
            end
            chk("in_ready", 64'(in_ready), 64'(in_idx < end_cnt));
            chk("busy", 64'(busy), 64'(in_idx > 0));
            chk("exp_req_valid", 64'(exp_req_valid), 64'(in_idx == end_cnt && req_idx < end_cnt));
            chk("out_valid", 64'(out_valid), 64'(rsp_idx == end_cnt && out_idx < end_cnt));
            if (len_err) obs_err++;
            if (in_valid && in_ready) in_idx++;
            if (exp_req_valid && exp_req_ready) begin
                chk("exp_req_data", 64'(exp_req_data), 64'(exp_req[req_idx]));
                if (req_idx == 0) req0 = exp_req_data;
                if (req_idx == 1) req1 = exp_req_data;
                due_q.push_back(cyc + lat);
                req_idx++;
            end
            if (exp_rsp_valid) rsp_idx++;
            if (out_valid) begin
                chk("out_exp", 64'(out_exp), 64'(rv[out_idx]));
                chk("out_sum", 64'(out_sum), 64'(sum));
                chk("out_last", 64'(out_last), 64'(out_idx == end_cnt - 1));
                obs_sum = longint'(out_sum);
                if (out_ready) out_idx++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        obs_n = out_idx;
        if (!aborted) begin
            chk("timeout_outputs", 64'(out_idx), 64'(end_cnt));
            chk("len_err_pulses", 64'(obs_err), 64'(end_cnt != eff));
            chk("request_count", 64'(req_idx), 64'(end_cnt));
        end
        drive_idle();
    endtask

    vec_t   tbl [4];
    longint o_sum;
    int     o_n, o_err;
    logic [DATA_W-1:0] r0, r1;
    smp_arr_t s;
    rsp_arr_t r;

    initial begin
        rst     = 1'b1;
        cfg_len = '0;
        drive_idle();

        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < NMAX; j++) begin
                tbl[i].smp[j] = '0;
                tbl[i].rv[j]  = '0;
            end
        end
        tbl[0].name = "basic";     tbl[0].cfg = 4; tbl[0].last_idx = 3; tbl[0].lat = 3; tbl[0].opat = 4'b1111;
        tbl[0].smp[0] = 34'h1_0000; tbl[0].smp[1] = 34'h2_0000; tbl[0].smp[2] = 34'h3_0000; tbl[0].smp[3] = 34'h8000;
        tbl[0].rv[0] = 10; tbl[0].rv[1] = 20; tbl[0].rv[2] = 30; tbl[0].rv[3] = 40;
        tbl[0].exp_sum = 100; tbl[0].exp_n = 4; tbl[0].exp_err = 0;
        tbl[0].exp_req0 = 34'h3_FFFE_0000; tbl[0].exp_req1 = 34'h3_FFFF_0000;
        tbl[1] = tbl[0];
        tbl[1].name = "stall"; tbl[1].opat = 4'b1001;
        tbl[2] = tbl[0];
        tbl[2].name = "short"; tbl[2].last_idx = 1;
        tbl[2].exp_sum = 30; tbl[2].exp_n = 2; tbl[2].exp_err = 1;
        tbl[2].exp_req0 = 34'h3_FFFF_0000; tbl[2].exp_req1 = 34'h0;
        tbl[3] = tbl[0];
        tbl[3].name = "saturate"; tbl[3].cfg = 2; tbl[3].last_idx = 1; tbl[3].lat = 1;
        tbl[3].smp[0] = 34'h1_FFFF_FFFF; tbl[3].smp[1] = 34'h2_0000_0000;
        tbl[3].rv[0] = 5; tbl[3].rv[1] = 7;
        tbl[3].exp_sum = 12; tbl[3].exp_n = 2; tbl[3].exp_err = 0;
        tbl[3].exp_req0 = 34'h0; tbl[3].exp_req1 = 34'h2_0000_0000;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_exp_req_valid", 64'(exp_req_valid), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_len_err", 64'(len_err), 64'd0);
        chk("rst_out_sum", 64'(out_sum), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        foreach (tbl[i]) begin
            run_vector(tbl[i].cfg, tbl[i].smp, tbl[i].last_idx, tbl[i].lat, 100, 1'b0, tbl[i].opat,
                       tbl[i].rv, 0, o_sum, o_n, o_err, r0, r1);
            chk({tbl[i].name, "_sum"}, 64'(o_sum), 64'(tbl[i].exp_sum));
            chk({tbl[i].name, "_nout"}, 64'(o_n), 64'(tbl[i].exp_n));
            chk({tbl[i].name, "_len_err"}, 64'(o_err), 64'(tbl[i].exp_err));
            chk({tbl[i].name, "_req0"}, 64'(r0), 64'(tbl[i].exp_req0));
            chk({tbl[i].name, "_req1"}, 64'(r1), 64'(tbl[i].exp_req1));
            @(negedge clk);
            chk({tbl[i].name, "_idle_in_ready"}, 64'(in_ready), 64'd1);
            chk({tbl[i].name, "_idle_busy"}, 64'(busy), 64'd0);
            @(posedge clk);
            #1;
        end

        // Randomized vectors, the first one full length with back-pressure on the exp port
        for (int k = 0; k < 8; k++) begin
            int cfg, last, lat;
            for (int j = 0; j < NMAX; j++) begin
                s[j] = {2'($urandom), 32'($urandom)};
                r[j] = 32'($urandom);
            end
            cfg  = (k == 0) ? 0  : int'($urandom_range(20));
            last = (k == 0) ? 15 : int'($urandom_range(16)) - 1;
            lat  = (k == 0) ? 5  : int'($urandom_range(6, 1));
            run_vector(cfg, s, last, lat, 60, 1'b1, 4'b0, r, 0, o_sum, o_n, o_err, r0, r1);
            @(posedge clk);
            #1;
        end

        // Reset while three exp requests are outstanding, then a clean vector
        for (int j = 0; j < NMAX; j++) begin
            s[j] = 34'(j * 32'h1000);
            r[j] = 32'(j + 1);
        end
        run_vector(8, s, 7, 5, 100, 1'b0, 4'b1111, r, 3, o_sum, o_n, o_err, r0, r1);
        rst = 1'b1;
        #1;
        chk("midexp_rst_in_ready", 64'(in_ready), 64'd1);
        chk("midexp_rst_busy", 64'(busy), 64'd0);
        chk("midexp_rst_req_valid", 64'(exp_req_valid), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        run_vector(tbl[0].cfg, tbl[0].smp, tbl[0].last_idx, tbl[0].lat, 100, 1'b0, 4'b1111,
                   tbl[0].rv, 0, o_sum, o_n, o_err, r0, r1);
        chk("post_rst_sum", 64'(o_sum), 64'd100);
        chk("post_rst_nout", 64'(o_n), 64'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/softmax_vec_ctrl.md
Name: softmax_vec_ctrl

Overview:
Vector-level softmax sequencer. It sits between the fixed-point input converter (signed z_in style samples) and the shared exp unit and divider.
- Buffers one vector of up to MAX_LEN samples and finds the maximum while loading.
- Issues (x_i − max) to an external exp unit, accumulates the exp sum, then streams each exp_i with the final sum to the divider.
- Generalises the single-sample softmax top to runtime vector length, a pipelined exp unit with in-flight tracking, and full valid/ready flow control.

Parameters:
DATA_W, 34, signed fixed-point sample width.
FRAC_W, 16, fractional bits of samples (documentation/test only; no arithmetic dependence).
MAX_LEN, 16, maximum vector length; buffer depth.
EXP_W, 32, unsigned exp result width.
SUM_W, EXP_W+$clog2(MAX_LEN), localparam, sum width; cannot overflow.
LEN_W, $clog2(MAX_LEN+1), localparam, length field width.

Ports:
clk  in  1  sole clock
rst  in  1  asynchronous, active-high reset
cfg_len  in  LEN_W  vector length, sampled on the first accepted input beat
in_valid  in  1  input sample valid
in_ready  out  1  high in IDLE and LOAD only
in_data  in  DATA_W  signed sample
in_last  in  1  marks the final sample of the vector
exp_req_valid  out  1  exp request valid
exp_req_ready  in  1  exp unit accepts the request
exp_req_data  out  DATA_W  signed x_i − max, always ≤ 0
exp_rsp_valid  in  1  exp result valid; responses return in request order, never more than requests issued
exp_rsp_data  in  EXP_W  exp result
out_valid  out  1  output valid
out_ready  in  1  downstream accepts
out_exp  out  EXP_W  exp_i
out_sum  out  SUM_W  sum of all exp_i in the vector, constant for the whole vector
out_last  out  1  marks the final output
len_err  out  1  one-cycle pulse on length mismatch
busy  out  1  state != IDLE

Behaviour:
Clock and reset:
- One clock, clk.
- Reset rst is asynchronous and active-high.
- Asserting rst at any time, including mid-vector, forces IDLE.
- Reset values: in_ready=1, all other outputs 0; counters, max and sum cleared; buffer contents don't-care.

States: IDLE, LOAD, EXP, OUT.
- IDLE: on an in_valid beat, latch len = (cfg_len==0 || cfg_len>MAX_LEN) ? MAX_LEN : cfg_len.
  - Write buf[0] and set max = in_data.
  - If in_last or len==1, go to EXP; else go to LOAD.
- LOAD: accept one sample per cycle; write buf[cnt]; update max = (in_data>max) ? in_data : max, signed compare.
  - Vector ends on in_last or on cnt==len, whichever comes first.
  - If the end is reached with cnt_final != len, pulse len_err on the end cycle and set len = cnt_final.
  - Transition to EXP on the next cycle.
- EXP: independent issue pointer (iss) and response pointer (rsp).
  - exp_req_valid = (iss<len); exp_req_data = sat_DATA_W(buf[iss] − max).
  - Difference is computed at DATA_W+1 bits and saturated to −2^(DATA_W−1).
  - iss increments on req valid&&ready, at most one per cycle.
  - On exp_rsp_valid: buf[rsp] ← exp_rsp_data, sum += exp_rsp_data, rsp++.
  - A response may arrive in the same cycle as its request is issued; a same-cycle read of buf[iss] and write of buf[rsp] with iss≠rsp is required.
  - When rsp==len, go to OUT.
- OUT: out_valid=1; out_exp=buf[optr]; out_sum=sum; out_last=(optr==len−1).
  - optr increments on out_valid&&out_ready.
  - The last handshake returns to IDLE with in_ready high the next cycle.
  - Outputs hold stable while out_ready is low.

Throughput: full-rate in every phase. A vector of n samples with exp latency L and no stalls completes in n + (n+L) + n cycles. No overlap between vectors: single buffer.

Buffer: width max(DATA_W, EXP_W). Samples are stored as DATA_W; exp results are zero-extended to the buffer width.

Decomposition:
- Shared package softmax_pkg: state enum (IDLE/LOAD/EXP/OUT), default widths DATA_W/EXP_W/FRAC_W, and the saturating-subtract function.
- One sub-module: softmax_vbuf, MAX_LEN×BUF_W register file with one synchronous write port and one asynchronous read port; the top multiplexes read address among iss and optr.

Test Plan:
- len=4, inputs 1.0, 2.0, 3.0, 0.5 (0x10000, 0x20000, 0x30000, 0x8000); exp model returns 10, 20, 30, 40 with latency 3 → req data −131072, −65536, 0, −163840; outputs 10, 20, 30, 40, out_sum=100, out_last on the 4th; len_err never pulses.
- Same vector, out_ready toggled 1-0-0-1 → no output lost or duplicated; out_exp/out_sum held stable while stalled.
- cfg_len=4, in_last on the 2nd sample → len_err pulses once; exactly 2 exp requests and 2 outputs; out_last on the 2nd.
- Inputs +2^33−1 and −2^33 → second request data saturates to −2^33 (0x2_0000_0000 as 34-bit); first request data = 0.
- cfg_len=0 and exp_req_ready randomly low with 16 samples and exp latency 5 (up to 5 in flight) → 16 requests in order; sum equals the model; in_ready is 0 until the final output handshake.
- rst asserted mid-EXP with 3 requests in flight → next cycle in_ready=1 and busy=0; a subsequent clean vector produces a correct sum, with no leftover responses counted once the bench flushes its model.
